// File: rtl/carry_normalizer_if.sv
// Stream bundle for carry_normalizer: parallel redundant limbs in, canonical words out.
// The slave modport is the normalizer; the master modport is its producer/consumer side.
interface carry_normalizer_if #(
  parameter int NUM_ELEMENTS = 17,
  parameter int BIT_LEN      = 17,
  parameter int WORD_LEN     = 16
);
  localparam int NUM_LIMBS = 2 * NUM_ELEMENTS;
  localparam int CARRY_BIT = BIT_LEN - WORD_LEN + 1;
  localparam int IDX_BIT   = $clog2(NUM_LIMBS);

  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_LEN-1:0]   in_limbs [NUM_LIMBS];
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_LEN-1:0]  out_word;
  logic [IDX_BIT-1:0]   out_idx;
  logic                 out_last;
  logic [CARRY_BIT-1:0] out_carry;

  modport master (
    output in_valid, in_limbs, out_ready,
    input  in_ready, out_valid, out_word, out_idx, out_last, out_carry
  );

  modport slave (
    input  in_valid, in_limbs, out_ready,
    output in_ready, out_valid, out_word, out_idx, out_last, out_carry
  );
endinterface

// File: rtl/carry_normalizer.sv
// Serial carry propagation: captures 2*NUM_ELEMENTS redundant limbs and streams the
// canonical product as WORD_LEN-bit words, least significant first, one per handshake.
module carry_normalizer #(
  parameter int NUM_ELEMENTS = 17,
  parameter int BIT_LEN      = 17,
  parameter int WORD_LEN     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  carry_normalizer_if.slave bus,
  output logic              busy
);
  localparam int NUM_LIMBS = 2 * NUM_ELEMENTS;
  localparam int CARRY_BIT = BIT_LEN - WORD_LEN + 1;
  localparam int IDX_BIT   = $clog2(NUM_LIMBS);
  localparam int SUM_W     = CARRY_BIT + WORD_LEN;
  localparam logic [IDX_BIT-1:0] LAST_IDX = IDX_BIT'(NUM_LIMBS - 1);

  generate
    if (BIT_LEN <= WORD_LEN) begin : g_bad_width
      $error("carry_normalizer: BIT_LEN must exceed WORD_LEN");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [CARRY_BIT-1:0] carry_q, carry_d;
  logic [IDX_BIT-1:0]   idx_q, idx_d;
  logic [BIT_LEN-1:0]   limb_buf_q [NUM_LIMBS];
  logic [BIT_LEN-1:0]   limb_buf_d [NUM_LIMBS];

  logic [SUM_W-1:0]     sum;
  logic [CARRY_BIT-1:0] next_carry;
  logic                 running;
  logic                 is_last;
  logic                 capture;
  logic                 advance;

  // SUM_W is BIT_LEN+1, so limb + carry can never overflow it.
  assign sum        = SUM_W'(limb_buf_q[idx_q]) + SUM_W'(carry_q);
  assign next_carry = sum[SUM_W-1:WORD_LEN];

  assign running = (state_q == RUN);
  assign is_last = running && (idx_q == LAST_IDX);
  assign advance = running && bus.out_ready;
  assign capture = bus.in_valid && bus.in_ready;
  assign busy    = running;

  // in_ready looks through out_ready so the next product lands on the last beat.
  assign bus.in_ready  = (state_q == IDLE) || (is_last && bus.out_ready);
  assign bus.out_valid = running;
  assign bus.out_word  = running ? sum[WORD_LEN-1:0] : '0;
  assign bus.out_idx   = running ? idx_q : '0;
  assign bus.out_last  = is_last;
  assign bus.out_carry = is_last ? next_carry : '0;

  always_comb begin
    state_d    = state_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    limb_buf_d = limb_buf_q;
    if (capture) begin
      state_d    = RUN;
      carry_d    = '0;
      idx_d      = '0;
      limb_buf_d = bus.in_limbs;
    end else if (advance) begin
      if (is_last) begin
        state_d = IDLE;
        carry_d = '0;
        idx_d   = '0;
      end else begin
        carry_d = next_carry;
        idx_d   = idx_q + IDX_BIT'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      carry_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  // The limb buffer carries no reset; its contents only matter after a capture.
  always_ff @(posedge clk) begin
    limb_buf_q <= limb_buf_d;
  end
endmodule

// File: tb/tb_carry_normalizer.sv
// Directed bench for carry_normalizer: expected words come from a wide-integer sum of
// the limbs, checked on every cycle of each stream including stalled ones.
module tb_carry_normalizer;
  localparam int NUM_ELEMENTS = 17;
  localparam int BIT_LEN      = 17;
  localparam int WORD_LEN     = 16;
  localparam int NUM_LIMBS    = 2 * NUM_ELEMENTS;
  localparam int CARRY_BIT    = BIT_LEN - WORD_LEN + 1;
  localparam int LAST         = NUM_LIMBS - 1;
  localparam int TOTAL_W      = NUM_LIMBS * WORD_LEN + CARRY_BIT;

  typedef logic [BIT_LEN-1:0] limb_arr_t [NUM_LIMBS];

  logic clk;
  logic rst_n;
  logic busy;
  int   checks;
  int   failures;

  carry_normalizer_if #(
    .NUM_ELEMENTS(NUM_ELEMENTS), .BIT_LEN(BIT_LEN), .WORD_LEN(WORD_LEN)
  ) bus ();

  carry_normalizer #(
    .NUM_ELEMENTS(NUM_ELEMENTS), .BIT_LEN(BIT_LEN), .WORD_LEN(WORD_LEN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [TOTAL_W-1:0] expectedTotal(input limb_arr_t limbs);
    logic [TOTAL_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_LIMBS; i++)
      acc = acc + (TOTAL_W'(limbs[i]) << (WORD_LEN * i));
    return acc;
  endfunction

  task automatic checkIdle(input string tag);
    #1;
    checkOutput({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    checkOutput({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
    checkOutput({tag, "_busy"},      64'(busy),          64'd0);
    checkOutput({tag, "_word"},      64'(bus.out_word),  64'd0);
    checkOutput({tag, "_idx"},       64'(bus.out_idx),   64'd0);
    checkOutput({tag, "_last"},      64'(bus.out_last),  64'd0);
    checkOutput({tag, "_carry"},     64'(bus.out_carry), 64'd0);
  endtask

  // Called at a negedge; returns at the negedge right after the capture edge and
  // then scrambles in_limbs so any late sampling would corrupt the stream.
  task automatic applyStimulus(input limb_arr_t limbs);
    int waitCycles;
    waitCycles = 0;
    bus.in_limbs = limbs;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && waitCycles < 100) begin
      @(negedge clk);
      #1;
      waitCycles++;
    end
    checkOutput("load_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < NUM_LIMBS; i++) bus.in_limbs[i] = ~limbs[i];
  endtask

  // Accepts stopAt beats, checking all outputs every cycle against the expected stream.
  task automatic drainProduct(input string tag, input logic [TOTAL_W-1:0] total,
                              input int stopAt, input int readyPct);
    int k;
    int cycles;
    k = 0;
    cycles = 0;
    while (k < stopAt && cycles < 40 * NUM_LIMBS) begin
      bus.out_ready = ($urandom_range(99) < readyPct);
      #1;
      checkOutput({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
      checkOutput({tag, "_busy"},      64'(busy),          64'd1);
      checkOutput({tag, "_idx"},       64'(bus.out_idx),   64'(k));
      checkOutput({tag, "_word"},      64'(bus.out_word),  64'(total[WORD_LEN*k +: WORD_LEN]));
      checkOutput({tag, "_last"},      64'(bus.out_last),  64'(k == LAST));
      checkOutput({tag, "_carry"},     64'(bus.out_carry),
                  (k == LAST) ? 64'(total >> (NUM_LIMBS * WORD_LEN)) : 64'd0);
      checkOutput({tag, "_in_ready"},  64'(bus.in_ready),  64'((k == LAST) && bus.out_ready));
      if (bus.out_ready) k++;
      @(negedge clk);
      cycles++;
    end
    bus.out_ready = 1'b0;
    checkOutput({tag, "_beats"}, 64'(k), 64'(stopAt));
    if (readyPct >= 100) checkOutput({tag, "_cycles"}, 64'(cycles), 64'(stopAt));
  endtask

  initial begin
    limb_arr_t satLimbs;
    limb_arr_t rippleLimbs;
    limb_arr_t rndLimbs;
    checks   = 0;
    failures = 0;
    rst_n        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NUM_LIMBS; i++) begin
      satLimbs[i]     = 17'h1FFFF;
      rippleLimbs[i]  = '0;
      bus.in_limbs[i] = '0;
    end
    rippleLimbs[0] = 17'h10000;
    rippleLimbs[1] = 17'h0FFFF;

    repeat (2) @(negedge clk);
    checkIdle("reset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    checkIdle("post_reset");
    @(negedge clk);

    $display("[TB] saturated limbs, full speed");
    applyStimulus(satLimbs);
    drainProduct("sat", expectedTotal(satLimbs), NUM_LIMBS, 100);
    checkIdle("sat_done");
    @(negedge clk);

    $display("[TB] ripple through saturated word");
    applyStimulus(rippleLimbs);
    drainProduct("ripple", expectedTotal(rippleLimbs), NUM_LIMBS, 100);
    checkIdle("ripple_done");
    @(negedge clk);

    $display("[TB] random limbs with backpressure");
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_LIMBS; i++) rndLimbs[i] = BIT_LEN'($urandom_range(0, 17'h1FFFF));
      applyStimulus(rndLimbs);
      drainProduct("rnd_bp", expectedTotal(rndLimbs), NUM_LIMBS, 50);
      checkIdle("rnd_bp_done");
      @(negedge clk);
    end

    $display("[TB] back-to-back products with in_valid held");
    applyStimulus(satLimbs);
    bus.in_limbs = rippleLimbs;
    bus.in_valid = 1'b1;
    drainProduct("b2b_a", expectedTotal(satLimbs), NUM_LIMBS, 100);
    bus.in_valid = 1'b0;
    for (int i = 0; i < NUM_LIMBS; i++) bus.in_limbs[i] = 17'h1ABCD;
    drainProduct("b2b_b", expectedTotal(rippleLimbs), NUM_LIMBS, 100);
    checkIdle("b2b_done");
    @(negedge clk);

    $display("[TB] reset mid-stream");
    applyStimulus(satLimbs);
    drainProduct("pre_rst", expectedTotal(satLimbs), 10, 100);
    rst_n = 1'b0;
    checkIdle("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    checkIdle("mid_reset_release");
    @(negedge clk);
    for (int i = 0; i < NUM_LIMBS; i++) rndLimbs[i] = BIT_LEN'($urandom_range(0, 17'h1FFFF));
    applyStimulus(rndLimbs);
    drainProduct("post_rst", expectedTotal(rndLimbs), NUM_LIMBS, 100);
    checkIdle("post_rst_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
